serial_pair_serializer: RTL and testbench
=========================================

Name: serial_pair_serializer

Overview:
- Parallel-to-serial transmitter that produces the bit-pair streams (a, b) consumed by the team's serial comparators.
- Accepts two W-bit words per valid/ready transfer and shifts them out one bit pair per accepted output cycle, MSB-first or LSB-first.
- Marks the first and last bit of each word so a downstream comparator can be re-armed per word.
- Sits between a word source (register file or test sequencer) and any serial_comparator_* instance.

Parameters:
- W, 8, word width in bits; W >= 2.
- MSB_FIRST, 1, 1 = most significant bit first; 0 = least significant bit first.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- in_valid  input  1  parallel word pair valid
- in_ready  output  1  serializer can accept a word pair
- in_a  input  W  word A
- in_b  input  W  word B
- out_valid  output  1  out_a/out_b carry a valid bit pair
- out_ready  input  1  downstream consumes the bit pair; tie 1 when feeding a comparator
- out_a  output  1  current bit of A
- out_b  output  1  current bit of B
- out_first  output  1  high with the first bit pair of a word
- out_last  output  1  high with the last bit pair of a word

Behaviour:
- Reset:
  - While rst is low: state=IDLE, shift registers=0, bit counter=0.
  - Outputs during reset: out_valid=0, out_first=0, out_last=0, out_a=0, out_b=0, in_ready=0.
  - in_ready rises in the first cycle after rst deasserts.
- FSM states: IDLE and SHIFT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready at a clock edge: capture in_a/in_b into shift registers, counter=0, go to SHIFT.
- SHIFT:
  - out_valid=1.
  - out_a/out_b = head bit of each register: bit W-1 if MSB_FIRST, else bit 0.
  - out_first = (counter==0).
  - out_last = (counter==W-1).
  - On out_valid & out_ready:
    - shift both registers toward the head by one bit;
    - counter+1;
    - if counter==W-1, word complete: go to IDLE (see Optional Feature for back-to-back).
  - out_ready=0: state, counter and all outputs hold stable; no bit is skipped or repeated.
- Timing and latency:
  - Word accepted at edge k → first bit pair valid in the cycle after edge k.
  - Word occupies exactly W transfer cycles.
- Handshake rules:
  - Transfer on either interface only when valid & ready are both high at a rising edge.
  - out_valid is never withdrawn without a transfer, except by reset.
- Counter: ceil(log2(W)) bits; never wraps past W-1.
- Reset mid-word: async abort; the partial word is discarded and never resumed. The next accepted word starts again with out_first.
- in_a/in_b are only sampled on an accepted transfer; changes at other times have no effect.

Optional Feature:
- Macro: SERIAL_PAIR_SERIALIZER_SKID_EN.
- Defined:
  - Adds a one-entry holding register (hold_a, hold_b, hold_valid).
  - in_ready = ~hold_valid in every non-reset state, including SHIFT.
  - A word accepted during SHIFT goes into the holding register.
  - On the last-bit transfer with hold_valid=1: load the shift registers from hold, clear hold_valid, stay in SHIFT. The next word's first bit follows with no bubble.
  - A simultaneous accept on the last-bit edge with hold empty loads the shift registers directly.
  - Throughput: 1 bit pair per cycle.
- Undefined:
  - in_ready=1 only in IDLE.
  - At least one idle cycle between words; throughput W/(W+1).

Test Plan:
- MSB_FIRST=1, W=8, in_a=8'hC4, in_b=8'h0F, out_ready=1 → out_a 1,1,0,0,0,1,0,0; out_b 0,0,0,0,1,1,1,1. out_first only on bit 1, out_last only on bit 8; out_valid high exactly 8 cycles.
- MSB_FIRST=0, same words → out_a 0,0,1,0,0,0,1,1; out_b 1,1,1,1,0,0,0,0.
- MSB_FIRST=1, out_ready low for 3 cycles while bit 3 is presented → bit 3 held stable; word completes in 11 cycles with an identical bit sequence; in_ready low throughout.
- Two words offered back-to-back (8'hC4/8'h0F then 8'h5A/8'h5B):
  - macro undefined → one out_valid=0 cycle between words, 17 cycles total;
  - macro defined → out_valid continuous for 16 cycles, out_first on cycles 1 and 9.
- rst pulled low while bit 5 of a word is presented → out_valid=0 in the same cycle; in_ready=1 the cycle after release. Next word 8'hFF/8'h00 is emitted in full starting with out_first.
- Integration: serializer (MSB_FIRST=1) drives serial_comparator_most_significant_first_using_fsm, comparator reset between words; words 8'h5A vs 8'h5B → a_less_b=1 on the out_last cycle.

Source files
------------

// File: rtl/serial_pair_serializer_if.sv
// Word-pair input and bit-pair output handshake bundle for serial_pair_serializer.
// master = word source / bit sink side, slave = the serializer itself.
interface serial_pair_serializer_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic         out_a;
  logic         out_b;
  logic         out_first;
  logic         out_last;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_first, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_first, out_last
  );
endinterface

// File: rtl/serial_pair_serializer.sv
// Parallel-to-serial bit-pair transmitter with first/last word markers.
// Define SERIAL_PAIR_SERIALIZER_SKID_EN for a one-entry holding register giving gapless words.
module serial_pair_serializer #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_pair_serializer_if.slave bus
);
  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  pair_t         sh_q, sh_d;
  pair_t         in_pair;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_xfer, out_xfer, at_last;

  function automatic logic [W-1:0] adv(input logic [W-1:0] v);
    return MSB_FIRST ? {v[W-2:0], 1'b0} : {1'b0, v[W-1:1]};
  endfunction

  function automatic logic head(input logic [W-1:0] v);
    return MSB_FIRST ? v[W-1] : v[0];
  endfunction

`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
  pair_t hold_q, hold_d;
  logic  hold_valid_q, hold_valid_d;

  // Ready tracks only the skid slot so a word can be parked while shifting.
  assign bus.in_ready = rst & ~hold_valid_q;
`else
  assign bus.in_ready = rst & (state_q == IDLE);
`endif

  assign in_pair       = '{a: bus.in_a, b: bus.in_b};
  assign in_xfer       = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state_q == SHIFT);
  assign out_xfer      = bus.out_valid & bus.out_ready;
  assign at_last       = (cnt_q == LAST);
  assign bus.out_a     = head(sh_q.a);
  assign bus.out_b     = head(sh_q.b);
  assign bus.out_first = bus.out_valid & (cnt_q == '0);
  assign bus.out_last  = bus.out_valid & at_last;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          sh_d    = in_pair;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_xfer) begin
          sh_d  = '{a: adv(sh_q.a), b: adv(sh_q.b)};
          cnt_d = cnt_q + 1'b1;
          if (at_last) begin
            cnt_d   = '0;
            state_d = IDLE;
`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
            // Chain the next word onto the last-bit edge: parked word first, else a fresh accept.
            if (hold_valid_q) begin
              sh_d         = hold_q;
              hold_valid_d = 1'b0;
              state_d      = SHIFT;
            end else if (in_xfer) begin
              sh_d    = in_pair;
              state_d = SHIFT;
            end
`endif
          end
        end
`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
        if (in_xfer && !(out_xfer && at_last)) begin
          hold_d       = in_pair;
          hold_valid_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_pair_serializer.sv
// Bench for serial_pair_serializer: MSB-first and LSB-first instances driven in lockstep,
// compared every cycle against a word-queue reference model plus directed scenario checks.
module tb_serial_pair_serializer;
  localparam int W = 8;

  logic clk;
  logic rst;

  serial_pair_serializer_if #(.W(W)) bus_m ();
  serial_pair_serializer_if #(.W(W)) bus_l ();

  serial_pair_serializer #(.W(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
  serial_pair_serializer #(.W(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: current word plus a FIFO of accepted-but-not-started words.
  logic         m_busy;
  int           m_pos;
  logic [W-1:0] m_cur_a, m_cur_b;
  logic [W-1:0] m_qa[$];
  logic [W-1:0] m_qb[$];

  int           cyc, n_valid, n_first, n_last, n_rdy_busy, t_first, t_last;
  logic [W-1:0] cap_ma, cap_mb, cap_la, cap_lb;
  logic         acc_dut;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic exp_rdy();
`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
    return m_qa.size() == 0;
`else
    return !m_busy;
`endif
  endfunction

  function automatic logic [5:0] exp_vec(input bit msb);
    int idx;
    logic a, b;
    idx = msb ? (W - 1 - m_pos) : m_pos;
    a = m_busy ? m_cur_a[idx] : 1'b0;
    b = m_busy ? m_cur_b[idx] : 1'b0;
    return {exp_rdy(), m_busy, a, b, m_busy && (m_pos == 0), m_busy && (m_pos == W - 1)};
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_pos  = 0;
    m_cur_a = '0;
    m_cur_b = '0;
    m_qa.delete();
    m_qb.delete();
  endtask

  task automatic model_update(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ordy);
    logic acc, done;
    acc  = iv && exp_rdy();
    done = 1'b0;
    if (m_busy && ordy) begin
      m_pos++;
      if (m_pos == W) done = 1'b1;
    end
    if (acc) begin
      m_qa.push_back(a);
      m_qb.push_back(b);
    end
    if ((!m_busy || done) && m_qa.size() > 0) begin
      m_cur_a = m_qa.pop_front();
      m_cur_b = m_qb.pop_front();
      m_pos   = 0;
      m_busy  = 1'b1;
    end else if (done) begin
      m_busy = 1'b0;
    end
  endtask

  function automatic logic [5:0] vec_m();
    return {bus_m.in_ready, bus_m.out_valid, bus_m.out_a, bus_m.out_b, bus_m.out_first, bus_m.out_last};
  endfunction

  function automatic logic [5:0] vec_l();
    return {bus_l.in_ready, bus_l.out_valid, bus_l.out_a, bus_l.out_b, bus_l.out_first, bus_l.out_last};
  endfunction

  task automatic clr();
    n_valid = 0; n_first = 0; n_last = 0; n_rdy_busy = 0;
    t_first = -1; t_last = -1;
    cap_ma = '0; cap_mb = '0; cap_la = '0; cap_lb = '0;
  endtask

  // One clock: drive at negedge, check before posedge, advance model at posedge.
  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
    bus_m.in_valid = iv; bus_m.in_a = a; bus_m.in_b = b; bus_m.out_ready = ordy;
    bus_l.in_valid = iv; bus_l.in_a = a; bus_l.in_b = b; bus_l.out_ready = ordy;
    #1;
    check("cycle_msb", 32'(vec_m()), 32'(exp_vec(1'b1)));
    check("cycle_lsb", 32'(vec_l()), 32'(exp_vec(1'b0)));
    acc_dut = iv & bus_m.in_ready;
    if (bus_m.out_valid) n_valid++;
    if (bus_m.out_valid && bus_m.in_ready) n_rdy_busy++;
    if (bus_m.out_valid && ordy) begin
      cap_ma = {cap_ma[W-2:0], bus_m.out_a};
      cap_mb = {cap_mb[W-2:0], bus_m.out_b};
      cap_la = {bus_l.out_a, cap_la[W-1:1]};
      cap_lb = {bus_l.out_b, cap_lb[W-1:1]};
      if (bus_m.out_first) begin
        n_first++;
        if (t_first < 0) t_first = cyc;
      end
      if (bus_m.out_last) begin
        n_last++;
        t_last = cyc;
      end
    end
    @(posedge clk);
    model_update(iv, a, b, ordy);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    acc_dut = 1'b0;
    for (int i = 0; i < 40 && !acc_dut; i++) step(1'b1, a, b, 1'b1);
    check("accept", 32'(acc_dut), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (m_busy || m_qa.size() > 0); i++) step(1'b0, W'($urandom), W'($urandom), 1'b1);
    check("drain_idle", 32'(bus_m.out_valid), 32'd0);
  endtask

  task automatic check_word(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    check({tag, "_msb_a"}, 32'(cap_ma), 32'(a));
    check({tag, "_msb_b"}, 32'(cap_mb), 32'(b));
    check({tag, "_lsb_a"}, 32'(cap_la), 32'(a));
    check({tag, "_lsb_b"}, 32'(cap_lb), 32'(b));
  endtask

  initial begin
    cyc = 0;
    clr();
    model_reset();
    rst = 1'b0;
    bus_m.in_valid = 1'b0; bus_m.in_a = '0; bus_m.in_b = '0; bus_m.out_ready = 1'b0;
    bus_l.in_valid = 1'b0; bus_l.in_a = '0; bus_l.in_b = '0; bus_l.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_msb", 32'(vec_m()), 32'd0);
    check("reset_lsb", 32'(vec_l()), 32'd0);
    rst = 1'b1;

    // Single word, free-running sink
    clr();
    send(8'hC4, 8'h0F);
    drain();
    check_word("single", 8'hC4, 8'h0F);
    check("single_valid_cycles", 32'(n_valid), 32'd8);
    check("single_first_cnt", 32'(n_first), 32'd1);
    check("single_last_cnt", 32'(n_last), 32'd1);

    // Sink stalls three cycles while bit 3 is presented
    clr();
    send(8'hC4, 8'h0F);
    step(1'b0, 8'h33, 8'h44, 1'b1);
    step(1'b0, 8'h55, 8'h66, 1'b1);
    repeat (3) step(1'b0, 8'h77, 8'h88, 1'b0);
    drain();
    check_word("stall", 8'hC4, 8'h0F);
    check("stall_valid_cycles", 32'(n_valid), 32'd11);
`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
    check("stall_ready_while_busy", 32'(n_rdy_busy), 32'd11);
`else
    check("stall_ready_while_busy", 32'(n_rdy_busy), 32'd0);
`endif

    // Two words offered back to back
    clr();
    send(8'hC4, 8'h0F);
    send(8'h5A, 8'h5B);
    drain();
    check_word("b2b_second", 8'h5A, 8'h5B);
    check("b2b_first_cnt", 32'(n_first), 32'd2);
    check("b2b_valid_cycles", 32'(n_valid), 32'd16);
`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
    check("b2b_span", 32'(t_last - t_first + 1), 32'd16);
`else
    check("b2b_span", 32'(t_last - t_first + 1), 32'd17);
`endif

    // Asynchronous reset while bit 5 is presented
    clr();
    send(8'hC4, 8'h0F);
    repeat (4) step(1'b0, 8'h00, 8'h00, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("midreset_msb", 32'(vec_m()), 32'd0);
    check("midreset_lsb", 32'(vec_l()), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 8'h12, 8'h34, 1'b1);
    clr();
    send(8'hFF, 8'h00);
    drain();
    check_word("after_reset", 8'hFF, 8'h00);
    check("after_reset_first_cnt", 32'(n_first), 32'd1);
    check("after_reset_valid_cycles", 32'(n_valid), 32'd8);

    // Random traffic: bursty source, stalling sink, data toggling when not accepted
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 2) != 0), W'($urandom), W'($urandom), 1'($urandom_range(0, 3) != 0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
